pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Parametrised pipeline control unit for the 5-stage MIPS core. It generalises stall/flush control to `STAGES` pipeline positions, each with its own stall request line. Exceptions become a flush burst of configurable length, with the redirect PC held stable for the whole burst. A stall watchdog flags pipelines frozen for too long. It sits beside the pipeline, fed by stage stall requests and by the MEM-stage exception/CP0 EPC signals; it drives the per-stage stall vector, flush and the redirect PC to the PC register.

## Interface
- `STAGES`, 6, number of stall positions (bit 0 = PC hold, bit k = stage k).
- `VEC_INT`, 32'h00000020, handler address for interrupts.
- `VEC_EXC`, 32'h00000040, handler address for all other synchronous exceptions.
- `FLUSH_CYCLES`, 1, cycles flush stays high per exception (≥1).
- `WDOG_MAX`, 255, consecutive stall cycles that trigger a timeout (≥1).
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stallreq_i`  in  STAGES  stall request; bit i requests a stall of stages 0..i.
- `excepttype_i`  in  32  exception code from MEM; zero = none.
- `cp0_epc_i`  in  32  EPC from CP0, used for eret.
- `stall_o`  out  STAGES  per-stage stall, 1 = hold.
- `flush_o`  out  1  pipeline flush.
- `new_pc_o`  out  32  redirect PC; valid while `flush_o`=1, else 0.
- `flush_busy_o`  out  1  high while in FLUSH state, after the first flush cycle.
- `wdog_timeout_o`  out  1  one-cycle pulse on watchdog expiry.

## Operation
- FSM states: RUN, FLUSH.
- RUN with `excepttype_i`≠0 triggers an exception entry:
  - `flush_o`=1 combinationally in the same cycle.
  - `stall_o`=0.
  - `new_pc_o` is decoded combinationally.
  - The decoded PC is latched into `pc_q`.
  - The counter is loaded with FLUSH_CYCLES-1.
  - If FLUSH_CYCLES>1, the next state is FLUSH; otherwise it stays RUN.
- PC decode:
  - 0x01 → VEC_INT.
  - 0x08, 0x0a, 0x0c, 0x0d → VEC_EXC.
  - 0x0e (eret) → `cp0_epc_i`.
  - Any other nonzero code → VEC_EXC.
- FLUSH state:
  - Outputs: `flush_o`=1, `new_pc_o`=`pc_q`, `stall_o`=0, `flush_busy_o`=1.
  - `excepttype_i` and `stallreq_i` are ignored; they belong to flushed instructions.
  - The counter decrements each cycle; at 0 the next state is RUN.
- RUN with no exception, stall decode:
  - k = highest set index of `stallreq_i`.
  - `stall_o[j]`=1 for j≤k, 0 above k.
  - All-zero requests give `stall_o`=0.
  - Examples: stage-3 request → 001111; stage-2 request → 000111.
  - `flush_o`=0 and `new_pc_o`=0.
- Priority: exception > stall requests. When both are present, stall_o=0.
- Watchdog:
  - `wcnt` increments each cycle `stall_o`≠0 and clears when `stall_o`=0 or on flush.
  - When `wcnt` reaches WDOG_MAX-1 while stalling, `wdog_timeout_o` pulses for one cycle.
  - After that, `wcnt` saturates at WDOG_MAX with no further pulse until the stall releases.
  - Width is clog2(WDOG_MAX+1).

## Timing
- Stall and first-cycle flush/new_pc are combinational from inputs (zero latency), as the pipeline registers require.
- Burst length: flush stays high for exactly FLUSH_CYCLES consecutive cycles per accepted exception.
- Back-to-back exceptions:
  - A new exception is accepted in the first RUN cycle after a burst.
  - With FLUSH_CYCLES=1, an exception every cycle gives flush every cycle, with the PC re-decoded each cycle.
- `wdog_timeout_o` is registered: it goes high the cycle after the WDOG_MAX-th consecutive stalled cycle.
- Reset values: state=RUN, counter=0, `pc_q`=0, `wcnt`=0.
- Output values while `rst`=1: `stall_o`=0, `flush_o`=0, `new_pc_o`=0, `flush_busy_o`=0, `wdog_timeout_o`=0.
- Reset asserted mid-burst aborts the burst; the next cycle after rst deasserts is RUN.

## Structure
- Shared package `pipe_ctrl_pkg`:
  - Exception codes EXC_INT=0x01, EXC_SYSCALL=0x08, EXC_RI=0x0a, EXC_OV=0x0c, EXC_TRAP=0x0d, EXC_ERET=0x0e.
  - FSM state enum.
- Sub-module `stall_mask`: parametrised priority-to-thermometer encoder (STAGES in, STAGES out).

## Test plan
- Stall decode: `stallreq_i`=001000 → `stall_o`=001111. `stallreq_i`=000100 → 000111. `stallreq_i`=001100 → 001111.
- Exception with stall: `excepttype_i`=0x0c while `stallreq_i`=001000 → same cycle `flush_o`=1, `new_pc_o`=0x40, `stall_o`=0.
- eret with FLUSH_CYCLES=3: code 0x0e, EPC=0x1234 for one cycle →
  - flush high 3 cycles, `new_pc_o`=0x1234 throughout.
  - `flush_busy_o` high in cycles 2–3.
  - An exception 0x01 injected in cycle 2 is ignored.
- Watchdog with WDOG_MAX=4: constant `stallreq_i`=000010 for 10 cycles → single `wdog_timeout_o` pulse in cycle 5. Releasing and re-stalling 4 cycles → second pulse.
- Reset mid-burst: FLUSH_CYCLES=4, `rst` in burst cycle 2 → all outputs 0. Next cycle with `excepttype_i`=0 → `flush_o`=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: MIPS exception codes,
// the controller FSM states and the redirect-PC decode.
package pipe_ctrl_pkg;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_RI      = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  typedef enum logic {
    RUN,
    FLUSH
  } state_t;

  // Interrupts and eret have dedicated targets; every other nonzero code
  // goes to the common exception vector.
  function automatic logic [31:0] decode_pc(input logic [31:0] code,
                                            input logic [31:0] epc,
                                            input logic [31:0] vec_int,
                                            input logic [31:0] vec_exc);
    case (code)
      EXC_INT:                                  decode_pc = vec_int;
      EXC_ERET:                                 decode_pc = epc;
      EXC_SYSCALL, EXC_RI, EXC_OV, EXC_TRAP:    decode_pc = vec_exc;
      default:                                  decode_pc = vec_exc;
    endcase
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_mask.sv
// Priority-to-thermometer encoder: a request at index k holds every
// position at or below k.
module stall_mask #(
  parameter int STAGES = 6
) (
  input  logic [STAGES-1:0] req,
  output logic [STAGES-1:0] mask
);

  logic acc;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it holding its old value and no latch is inferred.
  always_comb begin
    acc  = 1'b0;
    mask = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc     = acc | req[i];
      mask[i] = acc;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: thermometer stall decode, exception flush
// bursts with a held redirect PC, and a stall watchdog.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int          STAGES       = 6,
  parameter logic [31:0] VEC_INT      = 32'h0000_0020,
  parameter logic [31:0] VEC_EXC      = 32'h0000_0040,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          WDOG_MAX     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq_i,
  input  logic [31:0]       excepttype_i,
  input  logic [31:0]       cp0_epc_i,
  output logic [STAGES-1:0] stall_o,
  output logic              flush_o,
  output logic [31:0]       new_pc_o,
  output logic              flush_busy_o,
  output logic              wdog_timeout_o
);

  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WW = $clog2(WDOG_MAX + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);
  localparam logic [WW-1:0] WCNT_MAX  = WW'(WDOG_MAX);
  localparam logic [WW-1:0] WCNT_LAST = WW'(WDOG_MAX - 1);

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [31:0]       pc_q;
  logic [WW-1:0]     wcnt;
  logic              wdog_q;
  logic [STAGES-1:0] mask;
  logic              exc_take;
  logic [31:0]       dec_pc;

  stall_mask #(.STAGES(STAGES)) u_stall_mask (
    .req  (stallreq_i),
    .mask (mask)
  );

  assign exc_take = (state == RUN) && (excepttype_i != 32'h0);
  assign dec_pc   = decode_pc(excepttype_i, cp0_epc_i, VEC_INT, VEC_EXC);

  // Outputs are combinational so the first flush cycle and stalls act with
  // zero latency; everything is forced low while reset is held.
  always_comb begin
    stall_o        = '0;
    flush_o        = 1'b0;
    new_pc_o       = 32'h0;
    flush_busy_o   = 1'b0;
    wdog_timeout_o = wdog_q & ~rst;
    if (!rst) begin
      if (state == FLUSH) begin
        flush_o      = 1'b1;
        new_pc_o     = pc_q;
        flush_busy_o = 1'b1;
      end else if (exc_take) begin
        flush_o  = 1'b1;
        new_pc_o = dec_pc;
      end else begin
        stall_o = mask;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      cnt    <= '0;
      pc_q   <= 32'h0;
      wcnt   <= '0;
      wdog_q <= 1'b0;
    end else begin
      wdog_q <= 1'b0;
      if (stall_o != '0) begin
        if (wcnt == WCNT_LAST) begin
          wcnt   <= WCNT_MAX;
          wdog_q <= 1'b1;
        end else if (wcnt != WCNT_MAX) begin
          wcnt <= wcnt + 1'b1;
        end
      end else begin
        wcnt <= '0;
      end

      case (state)
        RUN: begin
          if (exc_take) begin
            pc_q <= dec_pc;
            cnt  <= CNT_LOAD;
            if (FLUSH_CYCLES > 1) state <= FLUSH;
          end
        end
        FLUSH: begin
          // Leaving when the counter steps to zero makes the burst exactly
          // FLUSH_CYCLES long including the entry cycle.
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench: three pipe_ctrl instances (burst lengths 1, 3, 4) share
// stimulus and are compared each cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int N   = 3;
  localparam int WM  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq;
  logic [31:0] excepttype;
  logic [31:0] epc;

  logic [5:0]  stall   [N];
  logic        flush   [N];
  logic [31:0] new_pc  [N];
  logic        busy    [N];
  logic        timeout [N];

  int fc [N];
  int burst_left [N];
  logic [31:0] burst_pc [N];
  int run_len [N];
  bit pulse [N];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.STAGES(6), .FLUSH_CYCLES(1), .WDOG_MAX(WM)) dut0 (
    .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(excepttype),
    .cp0_epc_i(epc), .stall_o(stall[0]), .flush_o(flush[0]), .new_pc_o(new_pc[0]),
    .flush_busy_o(busy[0]), .wdog_timeout_o(timeout[0]));

  pipe_ctrl #(.STAGES(6), .FLUSH_CYCLES(3), .WDOG_MAX(WM)) dut1 (
    .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(excepttype),
    .cp0_epc_i(epc), .stall_o(stall[1]), .flush_o(flush[1]), .new_pc_o(new_pc[1]),
    .flush_busy_o(busy[1]), .wdog_timeout_o(timeout[1]));

  pipe_ctrl #(.STAGES(6), .FLUSH_CYCLES(4), .WDOG_MAX(WM)) dut2 (
    .clk(clk), .rst(rst), .stallreq_i(stallreq), .excepttype_i(excepttype),
    .cp0_epc_i(epc), .stall_o(stall[2]), .flush_o(flush[2]), .new_pc_o(new_pc[2]),
    .flush_busy_o(busy[2]), .wdog_timeout_o(timeout[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pc(input logic [31:0] code, input logic [31:0] e);
    if (code == 32'h1) return 32'h20;
    if (code == 32'he) return e;
    return 32'h40;
  endfunction

  // One clock cycle: apply inputs, check all instances mid-cycle, then advance
  // the model across the rising edge.
  task automatic cycle(input logic r, input logic [5:0] req,
                       input logic [31:0] exc, input logic [31:0] e);
    logic [5:0]  e_stall [N];
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
    @(negedge clk);
    rst = r; stallreq = req; excepttype = exc; epc = e;
    #2;
    for (int c = 0; c < N; c++) begin
      e_stall[c] = '0; e_flush = 1'b0; e_pc = 32'h0; e_busy = 1'b0;
      if (!r) begin
        if (burst_left[c] > 0) begin
          e_flush = 1'b1; e_pc = burst_pc[c]; e_busy = 1'b1;
        end else if (exc != 0) begin
          e_flush = 1'b1; e_pc = model_pc(exc, e);
        end else begin
          for (int j = 0; j < 6; j++) e_stall[c][j] = ((req >> j) != 6'd0);
        end
      end
      check($sformatf("stall%0d", c), 32'(stall[c]), 32'(e_stall[c]));
      check($sformatf("flush%0d", c), 32'(flush[c]), 32'(e_flush));
      check($sformatf("new_pc%0d", c), new_pc[c], e_pc);
      check($sformatf("busy%0d", c), 32'(busy[c]), 32'(e_busy));
      check($sformatf("timeout%0d", c), 32'(timeout[c]), 32'(pulse[c] && !r));
    end
    @(posedge clk);
    for (int c = 0; c < N; c++) begin
      if (r) begin
        burst_left[c] = 0; run_len[c] = 0; pulse[c] = 1'b0;
      end else begin
        pulse[c]   = (e_stall[c] != 0) && (run_len[c] + 1 == WM);
        run_len[c] = (e_stall[c] != 0) ? run_len[c] + 1 : 0;
        if (burst_left[c] > 0) begin
          burst_left[c]--;
        end else if (exc != 0) begin
          burst_left[c] = fc[c] - 1;
          burst_pc[c]   = model_pc(exc, e);
        end
      end
    end
  endtask

  logic [31:0] codes [7];
  logic [5:0]  rq;
  logic [31:0] ex;

  initial begin
    fc[0] = 1; fc[1] = 3; fc[2] = 4;
    for (int c = 0; c < N; c++) begin
      burst_left[c] = 0; burst_pc[c] = 0; run_len[c] = 0; pulse[c] = 1'b0;
    end
    codes = '{32'h1, 32'h8, 32'ha, 32'hc, 32'hd, 32'he, 32'h7};
    rst = 1'b1; stallreq = '0; excepttype = '0; epc = '0;

    cycle(1'b1, 6'b001000, 32'hc, 32'h0);
    cycle(1'b1, 6'b000000, 32'h0, 32'h0);

    cycle(1'b0, 6'b001000, 32'h0, 32'h0);
    cycle(1'b0, 6'b000100, 32'h0, 32'h0);
    cycle(1'b0, 6'b001100, 32'h0, 32'h0);
    cycle(1'b0, 6'b000000, 32'h0, 32'h0);

    cycle(1'b0, 6'b001000, 32'hc, 32'h0);
    repeat (4) cycle(1'b0, 6'b000000, 32'h0, 32'h0);

    cycle(1'b0, 6'b000000, 32'he, 32'h1234);
    cycle(1'b0, 6'b000010, 32'h1, 32'h0);
    cycle(1'b0, 6'b000000, 32'h0, 32'h0);
    repeat (3) cycle(1'b0, 6'b000000, 32'h0, 32'h0);

    repeat (10) cycle(1'b0, 6'b000010, 32'h0, 32'h0);
    cycle(1'b0, 6'b000000, 32'h0, 32'h0);
    repeat (4) cycle(1'b0, 6'b000010, 32'h0, 32'h0);
    repeat (2) cycle(1'b0, 6'b000000, 32'h0, 32'h0);

    cycle(1'b0, 6'b000000, 32'h8, 32'h0);
    cycle(1'b1, 6'b000001, 32'h1, 32'h0);
    cycle(1'b0, 6'b000000, 32'h0, 32'h0);
    cycle(1'b0, 6'b000100, 32'h0, 32'h0);

    cycle(1'b0, 6'b000000, 32'h1, 32'h0);
    cycle(1'b0, 6'b000000, 32'hd, 32'h0);
    cycle(1'b0, 6'b000000, 32'he, 32'habcd);
    repeat (4) cycle(1'b0, 6'b000000, 32'h0, 32'h0);

    rq = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 0) rq = 6'($urandom_range(0, 63));
      ex = ($urandom_range(0, 4) == 0) ? codes[$urandom_range(0, 6)] : 32'h0;
      if (ex == 32'h7) ex = $urandom | 32'h1;
      cycle(($urandom_range(0, 39) == 0), rq, ex, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
